wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the 8-bit pipelined processor, directly downstream of the memory stage. It contains the MEM/WB pipeline register, selects the write-back value (ALU result or load data), and owns the 8 × 8-bit register file. It serves two combinational read ports to decode, exports forwarding information to the hazard/forwarding logic, and keeps a retired-instruction counter.

## Interface
Parameters:
- none

Ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- hold  in  1  freeze the MEM/WB register
- flush  in  1  load a bubble into the MEM/WB register
- validIn  in  1  memory-stage slot holds a real instruction
- regWriteIn  in  1  instruction writes a register
- memToRegIn  in  1  1 selects load data, 0 selects ALU result
- RdIn  in  3  destination register
- ALUResIn  in  8  ALU result forwarded from the memory stage
- readDataIn  in  8  data-memory read data, valid in the same cycle as ALUResIn
- rs1Addr, rs2Addr  in  3 each  decode read addresses
- rs1Data, rs2Data  out  8 each  register read data (combinational)
- wbRegWrite  out  1  a write commits at the next edge
- wbRd  out  3  write-back destination
- wbData  out  8  write-back value
- retireCount  out  16  count of retired instructions

## Operation
- MEM/WB register fields: valid, regWrite, memToReg, Rd, ALURes, readData, plus an internal `committed` flag.
- Priority at each posedge: flush > hold > load.
  - flush: valid←0, committed←0; other fields don't-care.
  - hold: all fields keep their value; committed←valid.
  - load: all fields capture the corresponding inputs; committed←0.
- wbData = memToReg ? readData : ALURes.
- wbRd = Rd.
- wbRegWrite = valid & regWrite & !committed & (Rd ≠ 0).
- Register file write: at the posedge where wbRegWrite=1, regs[wbRd]←wbData. The write uses the pre-edge register contents, so it happens even when the same edge flushes or holds.
- R0 reads as 0 and is never written.
- Reads: rsXData = regs[rsXAddr], with R0 forced to 0. Optional same-cycle bypass is described under Configuration.
- retireCount increments by 1 (mod 2^16, wraps 0xFFFF→0x0000) at every posedge where valid & !committed, whether or not the instruction writes a register.
- A held instruction commits exactly once: on its first cycle in MEM/WB.

## Timing
- Reset (rst_n=0, asynchronous), all outputs:
  - valid=0, committed=0, regWrite=0, memToReg=0, Rd=0, ALURes=0, readData=0.
  - All registers 0.
  - retireCount=0.
  - Resulting outputs: wbRegWrite=0, wbRd=0, wbData=0, rs1Data=rs2Data=0.
- Deassertion of rst_n is assumed synchronous to clk.
- Reset mid-operation discards the instruction in MEM/WB; its write does not occur.
- Latency: an instruction presented at edge N is written to the register file at edge N+1. The data is visible on read ports after edge N+1, or during cycle N..N+1 when the bypass is enabled.
- Forwarding outputs (wbRegWrite, wbRd, wbData) are valid throughout the cycle after capture.
- Simultaneous hold and flush: flush wins.

## Configuration
- WB_BYPASS_EN defined:
  - If rsXAddr == wbRd, wbRegWrite=1 and rsXAddr≠0, then rsXData = wbData (write-before-read within the cycle).
- WB_BYPASS_EN undefined:
  - Reads return array contents only. Decode sees a value one cycle after the write edge, and the hazard unit must cover that extra cycle.

## Test plan
- Reset: drive rst_n=0 mid-cycle with a valid write in flight -> all outputs 0 immediately; after release, regs all 0 and retireCount=0.
- ALU write-back: load validIn=1, regWriteIn=1, memToRegIn=0, RdIn=3, ALUResIn=0x5A -> next cycle wbRegWrite=1, wbData=0x5A; after the following edge rs1Addr=3 gives 0x5A; retireCount=1.
- Load write-back with bypass: memToRegIn=1, RdIn=5, readDataIn=0xC3, rs2Addr=5 in the write cycle -> rs2Data=0xC3 with WB_BYPASS_EN defined, old value (0x00) without it.
- R0 protection: RdIn=0, ALUResIn=0xFF, regWriteIn=1 -> wbRegWrite=0; rs1Addr=0 reads 0x00; retireCount still increments.
- Hold: load RdIn=2, ALURes=0x11, then hold=1 for 3 cycles -> exactly one write and retireCount +1 in total; wbRegWrite=0 during the held cycles.
- Flush and wrap: flush=1 with validIn=1 -> no write, retireCount unchanged; preload retireCount to 0xFFFF (via 65535 retires) and retire once more -> 0x0000.

Source files
------------

// File: rtl/wb_stage_if.sv
// wb_stage_if: memory-stage handshake, decode read ports and forwarding
// outputs of the write-back stage, bundled as one interface.
// master = the upstream/decode side, slave = wb_stage itself.
interface wb_stage_if;
    logic        hold;
    logic        flush;
    logic        validIn;
    logic        regWriteIn;
    logic        memToRegIn;
    logic [2:0]  RdIn;
    logic [7:0]  ALUResIn;
    logic [7:0]  readDataIn;
    logic [2:0]  rs1Addr;
    logic [2:0]  rs2Addr;
    logic [7:0]  rs1Data;
    logic [7:0]  rs2Data;
    logic        wbRegWrite;
    logic [2:0]  wbRd;
    logic [7:0]  wbData;
    logic [15:0] retireCount;

    modport master (
        output hold, flush, validIn, regWriteIn, memToRegIn, RdIn,
               ALUResIn, readDataIn, rs1Addr, rs2Addr,
        input  rs1Data, rs2Data, wbRegWrite, wbRd, wbData, retireCount
    );

    modport slave (
        input  hold, flush, validIn, regWriteIn, memToRegIn, RdIn,
               ALUResIn, readDataIn, rs1Addr, rs2Addr,
        output rs1Data, rs2Data, wbRegWrite, wbRd, wbData, retireCount
    );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register, write-back mux, 8x8 register file
// (R0 hardwired to zero) and a 16-bit retired-instruction counter.
// Optional feature macro: WB_BYPASS_EN -- when defined, a read of the
// register being written this cycle returns the write-back value.
module wb_stage (
    input  logic         clk,
    input  logic         rst_n,
    wb_stage_if.slave    bus
);
    // MEM/WB register fields
    logic        valid_q,     valid_d;
    logic        committed_q, committed_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic [2:0]  rd_q,        rd_d;
    logic [7:0]  alu_res_q,   alu_res_d;
    logic [7:0]  read_data_q, read_data_d;

    // Architectural state
    logic [7:0]  regs_q [8];
    logic [7:0]  regs_d [8];
    logic [15:0] retire_count_q, retire_count_d;

    // Write-back view of the current MEM/WB contents
    logic        wb_reg_write_s;
    logic [7:0]  wb_data_s;
    logic        retire_s;
    logic [7:0]  rs1_data_s;
    logic [7:0]  rs2_data_s;

    // Register-file read with R0 forced to zero and optional same-cycle bypass
    function automatic logic [7:0] rf_read(
        input logic [2:0] addr,
        input logic [7:0] arr [8],
        input logic       wr_en,
        input logic [2:0] wr_addr,
        input logic [7:0] wr_data
    );
        logic [7:0] val;
        if (addr == 3'd0) begin
            val = 8'h00;
        end else begin
`ifdef WB_BYPASS_EN
            if (wr_en && (wr_addr == addr)) begin
                val = wr_data;
            end else begin
                val = arr[addr];
            end
`else
            val = arr[addr];
`endif
        end
        return val;
    endfunction

    // Write-back select and commit qualification from pre-edge MEM/WB state
    always_comb begin
        wb_data_s      = mem_to_reg_q ? read_data_q : alu_res_q;
        retire_s       = valid_q & ~committed_q;
        wb_reg_write_s = retire_s & reg_write_q & (rd_q != 3'd0);
    end

    // MEM/WB next state: flush beats hold beats load; a held slot is marked committed
    always_comb begin
        valid_d      = valid_q;
        committed_d  = committed_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        rd_d         = rd_q;
        alu_res_d    = alu_res_q;
        read_data_d  = read_data_q;
        if (bus.flush) begin
            valid_d     = 1'b0;
            committed_d = 1'b0;
        end else if (bus.hold) begin
            committed_d = valid_q;
        end else begin
            valid_d      = bus.validIn;
            committed_d  = 1'b0;
            reg_write_d  = bus.regWriteIn;
            mem_to_reg_d = bus.memToRegIn;
            rd_d         = bus.RdIn;
            alu_res_d    = bus.ALUResIn;
            read_data_d  = bus.readDataIn;
        end
    end

    // Register-file and retire-counter next state (independent of flush/hold)
    always_comb begin
        regs_d = regs_q;
        if (wb_reg_write_s) begin
            regs_d[rd_q] = wb_data_s;
        end else begin
            regs_d = regs_q;
        end
        if (retire_s) begin
            retire_count_d = retire_count_q + 16'd1;
        end else begin
            retire_count_d = retire_count_q;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q        <= 1'b0;
            committed_q    <= 1'b0;
            reg_write_q    <= 1'b0;
            mem_to_reg_q   <= 1'b0;
            rd_q           <= 3'd0;
            alu_res_q      <= 8'h00;
            read_data_q    <= 8'h00;
            retire_count_q <= 16'd0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            valid_q        <= valid_d;
            committed_q    <= committed_d;
            reg_write_q    <= reg_write_d;
            mem_to_reg_q   <= mem_to_reg_d;
            rd_q           <= rd_d;
            alu_res_q      <= alu_res_d;
            read_data_q    <= read_data_d;
            retire_count_q <= retire_count_d;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Decode read ports
    always_comb begin
        rs1_data_s = rf_read(bus.rs1Addr, regs_q, wb_reg_write_s, rd_q, wb_data_s);
        rs2_data_s = rf_read(bus.rs2Addr, regs_q, wb_reg_write_s, rd_q, wb_data_s);
    end

    assign bus.rs1Data     = rs1_data_s;
    assign bus.rs2Data     = rs2_data_s;
    assign bus.wbRegWrite  = wb_reg_write_s;
    assign bus.wbRd        = rd_q;
    assign bus.wbData      = wb_data_s;
    assign bus.retireCount = retire_count_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage.
module tb_wb_stage;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    wb_stage_if bus ();

    wb_stage u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r,
                         input logic [2:0] rd, input logic [7:0] alu, input logic [7:0] rdat);
        bus.validIn    = v;
        bus.regWriteIn = rw;
        bus.memToRegIn = m2r;
        bus.RdIn       = rd;
        bus.ALUResIn   = alu;
        bus.readDataIn = rdat;
    endtask

    initial begin
        logic [7:0] byp_exp;
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.hold     = 1'b0;
        bus.flush    = 1'b0;
        bus.rs1Addr  = 3'd0;
        bus.rs2Addr  = 3'd0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);

        // Reset state
        step();
        check("rst_wbRegWrite", {15'd0, bus.wbRegWrite}, 16'd0);
        check("rst_wbRd", {13'd0, bus.wbRd}, 16'd0);
        check("rst_wbData", {8'd0, bus.wbData}, 16'd0);
        check("rst_retire", bus.retireCount, 16'd0);
        bus.rs1Addr = 3'd3;
        bus.rs2Addr = 3'd7;
        #1;
        check("rst_rs1", {8'd0, bus.rs1Data}, 16'd0);
        check("rst_rs2", {8'd0, bus.rs2Data}, 16'd0);
        rst_n = 1'b1;

        // ALU write-back to R3
        drive(1'b1, 1'b1, 1'b0, 3'd3, 8'h5A, 8'h77);
        step();
        check("alu_wbRegWrite", {15'd0, bus.wbRegWrite}, 16'd1);
        check("alu_wbRd", {13'd0, bus.wbRd}, 16'd3);
        check("alu_wbData", {8'd0, bus.wbData}, 16'h005A);
        check("alu_retire_pre", bus.retireCount, 16'd0);
`ifdef WB_BYPASS_EN
        byp_exp = 8'h5A;
`else
        byp_exp = 8'h00;
`endif
        check("alu_rs1_same_cycle", {8'd0, bus.rs1Data}, {8'd0, byp_exp});
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
        step();
        check("alu_rs1_after", {8'd0, bus.rs1Data}, 16'h005A);
        check("alu_retire", bus.retireCount, 16'd1);
        check("alu_idle_wbRegWrite", {15'd0, bus.wbRegWrite}, 16'd0);

        // Load write-back to R5
        drive(1'b1, 1'b1, 1'b1, 3'd5, 8'h12, 8'hC3);
        bus.rs2Addr = 3'd5;
        step();
        check("ld_wbData", {8'd0, bus.wbData}, 16'h00C3);
`ifdef WB_BYPASS_EN
        byp_exp = 8'hC3;
`else
        byp_exp = 8'h00;
`endif
        check("ld_rs2_same_cycle", {8'd0, bus.rs2Data}, {8'd0, byp_exp});
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
        step();
        check("ld_rs2_after", {8'd0, bus.rs2Data}, 16'h00C3);
        check("ld_retire", bus.retireCount, 16'd2);

        // R0 protection
        drive(1'b1, 1'b1, 1'b0, 3'd0, 8'hFF, 8'h00);
        bus.rs1Addr = 3'd0;
        step();
        check("r0_wbRegWrite", {15'd0, bus.wbRegWrite}, 16'd0);
        check("r0_rs1_same", {8'd0, bus.rs1Data}, 16'd0);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
        step();
        check("r0_rs1_after", {8'd0, bus.rs1Data}, 16'd0);
        check("r0_retire", bus.retireCount, 16'd3);

        // Hold for three cycles: one commit only
        drive(1'b1, 1'b1, 1'b0, 3'd2, 8'h11, 8'h00);
        bus.rs1Addr = 3'd2;
        step();
        check("hold_first_wbRegWrite", {15'd0, bus.wbRegWrite}, 16'd1);
        bus.hold = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'd2, 8'h99, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_wbRegWrite", {15'd0, bus.wbRegWrite}, 16'd0);
            check("hold_wbData", {8'd0, bus.wbData}, 16'h0011);
            check("hold_retire", bus.retireCount, 16'd4);
            check("hold_rs1", {8'd0, bus.rs1Data}, 16'h0011);
        end
        bus.hold = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
        step();
        check("hold_release_retire", bus.retireCount, 16'd4);

        // Flush with a valid instruction: no write, no retire
        bus.flush = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'd6, 8'h66, 8'h00);
        bus.rs1Addr = 3'd6;
        step();
        check("flush_wbRegWrite", {15'd0, bus.wbRegWrite}, 16'd0);
        check("flush_retire", bus.retireCount, 16'd4);
        // Flush together with hold: flush wins
        bus.hold = 1'b1;
        step();
        check("flushhold_wbRegWrite", {15'd0, bus.wbRegWrite}, 16'd0);
        bus.hold  = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
        step();
        check("flush_rs1", {8'd0, bus.rs1Data}, 16'd0);
        check("flush_retire_after", bus.retireCount, 16'd4);

        // Asynchronous reset with a write in flight
        drive(1'b1, 1'b1, 1'b0, 3'd4, 8'h44, 8'h00);
        step();
        check("midrst_pre_wbRegWrite", {15'd0, bus.wbRegWrite}, 16'd1);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
        #2;
        rst_n = 1'b0;
        bus.rs1Addr = 3'd3;
        bus.rs2Addr = 3'd4;
        #1;
        check("midrst_wbRegWrite", {15'd0, bus.wbRegWrite}, 16'd0);
        check("midrst_wbRd", {13'd0, bus.wbRd}, 16'd0);
        check("midrst_wbData", {8'd0, bus.wbData}, 16'd0);
        check("midrst_retire", bus.retireCount, 16'd0);
        check("midrst_rs1", {8'd0, bus.rs1Data}, 16'd0);
        step();
        rst_n = 1'b1;
        step();
        check("postrst_rs2", {8'd0, bus.rs2Data}, 16'd0);
        check("postrst_retire", bus.retireCount, 16'd0);

        // Retire-counter wrap
        drive(1'b1, 1'b0, 1'b0, 3'd1, 8'h00, 8'h00);
        repeat (65535) @(posedge clk);
        #1;
        check("wrap_fffe", bus.retireCount, 16'hFFFE);
        step();
        check("wrap_ffff", bus.retireCount, 16'hFFFF);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
        step();
        check("wrap_zero", bus.retireCount, 16'h0000);
        step();
        check("wrap_stays", bus.retireCount, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
